// File: rtl/smg_decoder.sv
// Receive-side decoder for a 4-digit multiplexed 7-segment display.
// It waits for each scan slot to settle, decodes it, and reassembles the 16-bit shown value.
//
// state      | meaning
// WAIT_FIRST | no valid digit captured since reset
// COLLECT    | gathering digits of the current frame
// COMPLETE   | one-cycle state after a frame lands in data (drives frame_done)
module smg_decoder #(
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sm_wei,
  input  logic [7:0]  sm_duan,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        frame_done,
  output logic        seg_err
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    COLLECT    = 2'd1,
    COMPLETE   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  state_t            state_q, state_d;
  logic [11:0]       s1_q, s2_q, held_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       shadow_q, shadow_d;
  logic [3:0]        mask_q, mask_d;
  logic [15:0]       data_q;
  logic              data_valid_q, seg_err_q;

  logic              accept, pos_ok, blank, nib_ok, valid_acc, err_acc, complete;
  logic [1:0]        pos;
  logic [3:0]        nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 12'hFFF;
      s2_q   <= 12'hFFF;
      held_q <= 12'hFFF;
      cnt_q  <= '0;
    end else begin
      s1_q <= {sm_wei, sm_duan};
      s2_q <= s1_q;
      if (s2_q != held_q) begin
        held_q <= s2_q;
        cnt_q  <= CNT_W'(1);
      end else if (cnt_q < STABLE) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Fires only on the edge where the counter reaches STABLE, so a held value is accepted once.
  assign accept = (s2_q == held_q) && (cnt_q == STABLE - 1'b1);

  always_comb begin
    pos    = 2'd0;
    pos_ok = 1'b0;
    blank  = 1'b0;
    case (held_q[11:8])
      4'b1110: begin pos = 2'd0; pos_ok = 1'b1; end
      4'b1101: begin pos = 2'd1; pos_ok = 1'b1; end
      4'b1011: begin pos = 2'd2; pos_ok = 1'b1; end
      4'b0111: begin pos = 2'd3; pos_ok = 1'b1; end
      4'b1111: blank = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    nib    = 4'h0;
    nib_ok = 1'b1;
    case (held_q[7:0])
      8'hC0: nib = 4'h0;
      8'hF9: nib = 4'h1;
      8'hA4: nib = 4'h2;
      8'hB0: nib = 4'h3;
      8'h99: nib = 4'h4;
      8'h92: nib = 4'h5;
      8'h82: nib = 4'h6;
      8'hF8: nib = 4'h7;
      8'h80: nib = 4'h8;
      8'h90: nib = 4'h9;
      8'h88: nib = 4'hA;
      8'h83: nib = 4'hB;
      8'hC6: nib = 4'hC;
      8'hA1: nib = 4'hD;
      8'h87: nib = 4'hE;
      8'h8E: nib = 4'hF;
      default: nib_ok = 1'b0;
    endcase
  end

  // Blank slots are silently dropped whatever the segment lines show.
  assign valid_acc = accept && pos_ok && nib_ok;
  assign err_acc   = accept && !blank && !(pos_ok && nib_ok);

  always_comb begin
    shadow_d                   = shadow_q;
    shadow_d[{pos, 2'b00} +: 4] = nib;
    mask_d                     = mask_q | (4'b0001 << pos);
  end

  assign complete = valid_acc && (mask_d == 4'b1111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      mask_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      seg_err_q    <= 1'b0;
    end else begin
      seg_err_q <= err_acc;
      if (valid_acc) begin
        shadow_q <= shadow_d;
        mask_q   <= complete ? 4'b0000 : mask_d;
      end
      if (complete) begin
        data_q       <= shadow_d;
        data_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_FIRST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FIRST: begin
        if (complete)       state_d = COMPLETE;
        else if (valid_acc) state_d = COLLECT;
      end
      COLLECT:  if (complete) state_d = COMPLETE;
      COMPLETE: state_d = complete ? COMPLETE : COLLECT;
      default:  state_d = WAIT_FIRST;
    endcase
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_done = (state_q == COMPLETE);
  assign seg_err    = seg_err_q;

endmodule

// File: tb/tb_smg_decoder.sv
// Bench for smg_decoder: pin-level stability model predicts every output cycle by cycle,
// plus directed frame checks and a randomized scan phase.
module tb_smg_decoder;
  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wei;
  logic [7:0]  duan;
  logic [15:0] data;
  logic        data_valid, frame_done, seg_err;

  smg_decoder #(.STABLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sm_wei(wei), .sm_duan(duan),
    .data(data), .data_valid(data_valid), .frame_done(frame_done), .seg_err(seg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  segtab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h87, 8'h8E};

  // reference model state
  logic [11:0] prev_pins;
  int          run;
  logic        p1_v, p2_v;
  logic [11:0] p1, p2;
  logic [3:0]  shadow [4];
  logic [3:0]  mmask;
  logic [15:0] exp_data;
  logic        exp_valid, exp_done, exp_err;

  int          done_seen, err_seen;
  logic [15:0] done_q [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    prev_pins = 12'hFFF;
    run = 0;
    p1_v = 1'b0; p2_v = 1'b0; p1 = '0; p2 = '0;
    for (int i = 0; i < 4; i++) shadow[i] = 4'h0;
    mmask = 4'h0;
    exp_data = 16'h0; exp_valid = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_accept(input logic [11:0] v);
    int pos, dig;
    pos = -1;
    dig = -1;
    if (v[11:8] == 4'hF) return;
    for (int p = 0; p < 4; p++) if (v[11:8] == ~(4'b0001 << p)) pos = p;
    for (int d = 0; d < 16; d++) if (segtab[d] == v[7:0]) dig = d;
    if (pos < 0 || dig < 0) begin
      exp_err = 1'b1;
    end else begin
      shadow[pos] = 4'(dig);
      mmask[pos]  = 1'b1;
      if (mmask == 4'hF) begin
        exp_data  = {shadow[3], shadow[2], shadow[1], shadow[0]};
        exp_done  = 1'b1;
        exp_valid = 1'b1;
        mmask     = 4'h0;
      end
    end
  endtask

  task automatic tick();
    logic [11:0] cur, fv;
    logic        fire;
    @(posedge clk);
    cur = {wei, duan};
    if (cur == prev_pins) run++; else run = 1;
    prev_pins = cur;
    fire = p2_v; fv = p2;
    p2_v = p1_v; p2 = p1;
    p1_v = (run == S); p1 = cur;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (fire) model_accept(fv);
    #1;
    chk("data", data, exp_data);
    chk("data_valid", 16'(data_valid), 16'(exp_valid));
    chk("frame_done", 16'(frame_done), 16'(exp_done));
    chk("seg_err", 16'(seg_err), 16'(exp_err));
    if (frame_done) begin done_seen++; done_q.push_back(data); end
    if (seg_err) err_seen++;
  endtask

  task automatic hold(input logic [3:0] w, input logic [7:0] d, input int n, output int done_at);
    wei = w; duan = d;
    done_at = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (frame_done && done_at < 0) done_at = i;
    end
  endtask

  task automatic digit(input int p, input int v, input int n);
    int unused;
    hold(~(4'b0001 << p), segtab[v], n, unused);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_data", data, 16'h0);
    chk("rst_valid", 16'(data_valid), 16'h0);
    chk("rst_done", 16'(frame_done), 16'h0);
    chk("rst_err", 16'(seg_err), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, d0, e0, w, u;
    logic [7:0] dv;
    rst_n = 1'b0;
    wei = 4'hF; duan = 8'hFF;
    done_seen = 0; err_seen = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // frame 9,7,6,5 with latency measured on the last slot
    d0 = done_seen; e0 = err_seen;
    digit(0, 9, 3*S); digit(1, 7, 3*S); digit(2, 6, 3*S);
    hold(4'b0111, segtab[5], 3*S, lat);
    chk("t1_latency", 16'(lat), 16'(S + 2));
    chk("t1_data", data, 16'h5679);
    chk("t1_valid", 16'(data_valid), 16'h1);
    chk("t1_done_cnt", 16'(done_seen - d0), 16'h1);
    chk("t1_err_cnt", 16'(err_seen - e0), 16'h0);

    // full table over four frames
    d0 = done_seen; done_q.delete();
    for (int f = 0; f < 4; f++)
      for (int p = 0; p < 4; p++) digit(p, 4*f + p, S + 3);
    hold(4'hF, 8'hFF, S + 3, u);
    chk("t2_done_cnt", 16'(done_seen - d0), 16'h4);
    if (done_q.size() == 4) begin
      chk("t2_f0", done_q[0], 16'h3210);
      chk("t2_f1", done_q[1], 16'h7654);
      chk("t2_f2", done_q[2], 16'hBA98);
      chk("t2_f3", done_q[3], 16'hFEDC);
    end

    // illegal duan (dp lit) and illegal wei
    d0 = done_seen; e0 = err_seen;
    hold(4'b1110, 8'h7F, 2*S, u);
    hold(4'b1100, 8'hC0, 2*S, u);
    chk("t3_err_cnt", 16'(err_seen - e0), 16'h2);
    chk("t3_done_cnt", 16'(done_seen - d0), 16'h0);
    chk("t3_data", data, 16'hFEDC);

    // short glitch on one segment bit
    d0 = done_seen; e0 = err_seen;
    hold(4'b1101, 8'hF9, 2*S, u);
    hold(4'b1101, 8'hF8, S - 1, u);
    hold(4'b1101, 8'hF9, 2*S, u);
    chk("t4_err_cnt", 16'(err_seen - e0), 16'h0);
    chk("t4_done_cnt", 16'(done_seen - d0), 16'h0);

    // reset in the middle of the digit-3 slot
    digit(0, 7, S + 3); digit(1, 7, S + 3); digit(2, 7, S + 3);
    digit(3, 7, 3);
    do_reset();
    e0 = err_seen;
    digit(0, 1, S + 3); digit(1, 2, S + 3); digit(2, 3, S + 3); digit(3, 4, S + 3);
    hold(4'hF, 8'hFF, S + 3, u);
    chk("t5_data", data, 16'h4321);
    chk("t5_err_cnt", 16'(err_seen - e0), 16'h0);

    // blank slots and a repeated digit0
    e0 = err_seen;
    digit(0, 3, S + 3); hold(4'hF, 8'hFF, S + 3, u);
    digit(1, 1, S + 3); hold(4'hF, 8'hC0, S + 3, u);
    digit(0, 8, S + 3); digit(2, 2, S + 3); hold(4'hF, 8'hFF, S + 3, u);
    digit(3, 4, S + 3); hold(4'hF, 8'hFF, S + 3, u);
    chk("t6_data", data, 16'h4218);
    chk("t6_err_cnt", 16'(err_seen - e0), 16'h0);

    // randomized scan traffic checked by the model every cycle
    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 2)       w = 4'hF;
      else if (r < 3)  w = ($urandom_range(0, 1) == 0) ? 4'b1100 : 4'b0000;
      else             w = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) dv = 8'($urandom);
      else                            dv = segtab[$urandom_range(0, 15)];
      hold(4'(w), dv, $urandom_range(S - 3, 2*S), u);
    end
    hold(4'hF, 8'hFF, S + 3, u);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/smg_decoder.md
Name: smg_decoder

Overview:
- Receive-side counterpart of the team's 4-digit multiplexed 7-segment driver.
- Monitors the scanned digit-select (sm_wei) and segment (sm_duan) lines, waits for each scan slot to settle, and decodes the active-low segment pattern back to a hex nibble.
- Reassembles the 16-bit value shown on the display.
- Used for board-to-board loopback and for self-checking display paths in hardware.

Parameters:
- STABLE_CYCLES, 1024: consecutive clk cycles a {wei,duan} value must hold before it is accepted; legal range 2..65535.
- CNT_W, 16: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sm_wei  input  4  digit select, active-low one-hot; 1110=digit0 (data[3:0]) … 0111=digit3 (data[15:12]).
- sm_duan  input  8  segment lines, active-low.
- data  output  16  last completely captured display value.
- data_valid  output  1  high once at least one full frame has been captured.
- frame_done  output  1  one-cycle pulse when data is updated.
- seg_err  output  1  one-cycle pulse on an accepted illegal wei or duan value.

Behaviour:
- Reset (rst_n low, async): data=16'h0000, data_valid=0, frame_done=0, seg_err=0. Sync stages and held value are set to 12'hFFF. Stability counter=0, capture mask=0, shadow=0, FSM=WAIT_FIRST.
- Input path: the 12 bits {sm_wei,sm_duan} pass through a 2-flop synchroniser (s1, s2).
- Stability tracking, every edge:
  - If s2 != held: held<=s2 and cnt<=1.
  - Else if cnt<STABLE_CYCLES: cnt<=cnt+1.
  - Else cnt saturates at STABLE_CYCLES.
- Accept event: fires exactly once per stable period, on the edge where cnt becomes STABLE_CYCLES. No re-accept while the value stays unchanged.
- Latency: outputs update on that same accept edge, i.e. the (STABLE_CYCLES+2)th rising edge after the pins settle.
- Digit select on accept:
  - 1110/1101/1011/0111 → position p = 0/1/2/3.
  - 1111 → blank slot; ignored with no error.
  - Any other value → seg_err pulse; no capture.
- Segment decode on accept: full 8-bit exact match required.
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, B=83, C=C6, D=A1, E=87, F=8E
  - Any other pattern, including a lit decimal point (bit7=0) → seg_err pulse; no capture.
  - If wei and duan are both illegal: a single seg_err pulse.
- Capture on a valid accept:
  - shadow[4p+3:4p] <= nibble; mask[p] <= 1.
  - A repeat of an already-captured position before frame completion overwrites shadow; no error.
- Frame completion: when mask|(1<<p) == 4'b1111 on an accept:
  - data <= shadow with the new nibble merged in the same edge.
  - frame_done=1 for that cycle; data_valid<=1; mask<=0.
- FSM:
  - WAIT_FIRST → COLLECT on the first valid accept.
  - COLLECT → COMPLETE for one cycle on frame completion, then back to COLLECT.
  - data_valid is 0 only in WAIT_FIRST before the first completion; once set it stays set until reset.
- Output hold: data holds its value between frames. Partial frames never reach data.
- Glitches: input changes shorter than STABLE_CYCLES cycles never cause capture or seg_err.
- Reset mid-frame: the partial shadow/mask is discarded and data returns to 0.
- No back-pressure: frame_done is informational only.

Test Plan:
- Reset, then drive wei=1110/1101/1011/0111 with duan=90/F8/82/92 (9,7,6,5), each held 3×STABLE_CYCLES → frame_done one pulse exactly STABLE_CYCLES+2 edges after the last slot settles; data=16'h5679; data_valid=1; seg_err never asserted.
- Cycle the full table 0–F over four frames (0123, 4567, 89AB, CDEF) → data=16'h3210, 16'h7654, 16'hBA98, 16'hFEDC in order; exactly 4 frame_done pulses.
- Settled wei=1110 with duan=7F (dp lit), then wei=1100 with duan=C0 → two seg_err pulses; mask unchanged; data unchanged; no frame_done.
- Hold wei=1101/duan=F9, toggle one duan bit for STABLE_CYCLES-1 cycles, then restore → no glitch capture; a single accept follows once the restored value holds STABLE_CYCLES cycles.
- Capture digits 0–2, assert rst_n low for 1 cycle mid digit-3 slot, then send a full frame 1234 → after reset data=0 and data_valid=0; after the frame data=16'h4321; no stale nibbles.
- Insert wei=1111 blank slots between digits and repeat digit0 with a new value (3 then 8) before digit3 → blanks ignored silently; data[3:0]=8 in the completed frame.
